// File: rtl/sseg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller.
// Includes a one-word shadow register, frame-aligned display commit and leading-zero blanking.
module sseg_scan_ctrl #(
  parameter int unsigned TICK_DIV = 50000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic [15:0] in_bcd_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [3:0]  digit_o,
  output logic [3:0]  an_o,
  output logic        blank_o,
  output logic        frame_done_o,
  output logic        bcd_err_o
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic [0:0] {ST_OFF, ST_SCAN} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  presc_q, presc_d;
  logic [1:0]        idx_q, idx_d;
  logic [15:0]       disp_q, disp_d;
  logic [15:0]       pend_q, pend_d;
  logic              pend_valid_q, pend_valid_d;
  logic              err_q, err_d;

  logic              tick_c;
  logic              commit_c;
  logic              pend_bad_c;
  logic              lz_blank_c;

  // State register; reset discards any pending word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_OFF;
      presc_q      <= '0;
      idx_q        <= '0;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      err_q        <= err_d;
    end
  end

  // Next-state: scan timing, shadow-register handshake and frame-aligned commit.
  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    idx_d        = idx_q;
    disp_d       = disp_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    err_d        = err_q;
    tick_c       = 1'b0;
    commit_c     = 1'b0;
    pend_bad_c   = 1'b0;

    for (int i = 0; i < 4; i++) begin
      if (pend_q[4*i +: 4] > 4'd9) pend_bad_c = 1'b1;
    end

    case (state_q)
      ST_OFF: begin
        presc_d  = '0;
        idx_d    = '0;
        commit_c = pend_valid_q;
        if (en_i) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        tick_c   = (presc_q == CNT_LAST);
        commit_c = pend_valid_q && tick_c && (idx_q == 2'd3);
        if (!en_i) begin
          state_d = ST_OFF;
          presc_d = '0;
          idx_d   = '0;
        end else if (tick_c) begin
          presc_d = '0;
          idx_d   = 2'(idx_q + 2'd1);
        end else begin
          presc_d = CNT_W'(presc_q + CNT_W'(1));
        end
      end
      default: state_d = ST_OFF;
    endcase

    // Commit needs pend_valid=1 and transfer needs pend_valid=0, so they never collide.
    if (commit_c) begin
      disp_d       = pend_q;
      pend_valid_d = 1'b0;
      err_d        = pend_bad_c;
    end else if (in_valid_i && !pend_valid_q) begin
      pend_d       = in_bcd_i;
      pend_valid_d = 1'b1;
    end
  end

  // Leading-zero blanking of the active slot; digit 0 always shows.
  always_comb begin
    lz_blank_c = 1'b0;
    case (idx_q)
      2'd3:    lz_blank_c = (disp_q[15:12] == 4'h0);
      2'd2:    lz_blank_c = (disp_q[15:8]  == 8'h00);
      2'd1:    lz_blank_c = (disp_q[15:4]  == 12'h000);
      default: lz_blank_c = 1'b0;
    endcase
    lz_blank_c = lz_blank_c && BLANK_LZ;
  end

  assign in_ready_o   = ~pend_valid_q;
  assign digit_o      = 4'(disp_q >> {idx_q, 2'b00});
  assign blank_o      = (state_q == ST_OFF) || lz_blank_c;
  assign an_o         = blank_o ? 4'hF : ~(4'b0001 << idx_q);
  assign frame_done_o = tick_c && (idx_q == 2'd3);
  assign bcd_err_o    = err_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl at TICK_DIV=4, BLANK_LZ=1.
module tb_sseg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en_i;
  logic [15:0] in_bcd_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [3:0]  digit_o;
  logic [3:0]  an_o;
  logic        blank_o;
  logic        frame_done_o;
  logic        bcd_err_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  sseg_scan_ctrl #(.TICK_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (en_i),
    .in_bcd_i     (in_bcd_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .digit_o      (digit_o),
    .an_o         (an_o),
    .blank_o      (blank_o),
    .frame_done_o (frame_done_o),
    .bcd_err_o    (bcd_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer a word for one edge while in_ready=1 (transfer), then drop in_valid.
  task automatic push(input logic [15:0] w);
    in_bcd_i   = w;
    in_valid_i = 1'b1;
    step(1);
    in_valid_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 16'(in_ready_o), 16'h1);
    check({tag, "_an"},    16'(an_o),       16'hF);
    check({tag, "_blank"}, 16'(blank_o),    16'h1);
    check({tag, "_digit"}, 16'(digit_o),    16'h0);
    check({tag, "_fd"},    16'(frame_done_o), 16'h0);
    check({tag, "_err"},   16'(bcd_err_o),  16'h0);
  endtask

  initial begin
    logic [3:0] an_exp;
    rst_n      = 1'b0;
    en_i       = 1'b0;
    in_bcd_i   = 16'h0;
    in_valid_i = 1'b0;

    #2;
    check_reset_outputs("rst0");
    step(2);
    rst_n = 1'b1;
    step(1);

    // Push 4321 while off; commit in OFF one cycle after the transfer.
    check("p1_ready_before", 16'(in_ready_o), 16'h1);
    push(16'h4321);
    check("p1_ready_pend", 16'(in_ready_o), 16'h0);
    step(1);
    check("p1_ready_after", 16'(in_ready_o), 16'h1);
    check("p1_off_an", 16'(an_o), 16'hF);
    check("p1_off_digit", 16'(digit_o), 16'h1);
    en_i = 1'b1;
    step(1);

    // Two full frames: 4 clk per slot, frame_done on last cycle of slot 3.
    for (int f = 0; f < 2; f++) begin
      for (int s = 0; s < 4; s++) begin
        for (int c = 0; c < 4; c++) begin
          an_exp = ~(4'b0001 << s);
          check($sformatf("scan_an_f%0d_s%0d_c%0d", f, s, c), 16'(an_o), 16'(an_exp));
          check($sformatf("scan_dig_f%0d_s%0d_c%0d", f, s, c), 16'(digit_o), 16'(s + 1));
          check($sformatf("scan_fd_f%0d_s%0d_c%0d", f, s, c), 16'(frame_done_o),
                16'((s == 3 && c == 3) ? 1 : 0));
          step(1);
        end
      end
    end

    // Push 1234 at idx=1; held in shadow until frame-end tick.
    step(4);
    check("p2_an_idx1", 16'(an_o), 16'hD);
    push(16'h1234);
    in_bcd_i   = 16'h5678;
    in_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("p2_ready_hold_%0d", i), 16'(in_ready_o), 16'h0);
      step(1);
    end
    check("p2_fd_tick", 16'(frame_done_o), 16'h1);
    check("p2_ready_tick", 16'(in_ready_o), 16'h0);
    check("p2_digit_old", 16'(digit_o), 16'h4);
    check("p2_an_slot3", 16'(an_o), 16'h7);
    step(1);
    check("p2_digit_new", 16'(digit_o), 16'h4);
    check("p2_an_slot0", 16'(an_o), 16'hE);
    check("p2_ready_back", 16'(in_ready_o), 16'h1);
    step(1);
    in_valid_i = 1'b0;
    check("p2_second_held", 16'(in_ready_o), 16'h0);
    check("p2_digit_stable", 16'(digit_o), 16'h4);

    // Drop en at idx=2 with 5678 pending.
    step(7);
    check("ab_an_idx2", 16'(an_o), 16'hB);
    check("ab_dig_idx2", 16'(digit_o), 16'h2);
    en_i = 1'b0;
    check("ab_fd_idx2", 16'(frame_done_o), 16'h0);
    step(1);
    check("ab_an_off", 16'(an_o), 16'hF);
    check("ab_blank_off", 16'(blank_o), 16'h1);
    check("ab_fd_off", 16'(frame_done_o), 16'h0);
    check("ab_digit_idx0", 16'(digit_o), 16'h4);
    check("ab_ready_pend", 16'(in_ready_o), 16'h0);
    step(1);
    check("ab_digit_commit", 16'(digit_o), 16'h8);
    check("ab_ready_free", 16'(in_ready_o), 16'h1);

    // Leading-zero blanking of 0042.
    push(16'h0042);
    step(1);
    en_i = 1'b1;
    step(1);
    check("lz_dig0", 16'(digit_o), 16'h2);
    check("lz_an0", 16'(an_o), 16'hE);
    check("lz_blank0", 16'(blank_o), 16'h0);
    step(4);
    check("lz_dig1", 16'(digit_o), 16'h4);
    check("lz_an1", 16'(an_o), 16'hD);
    step(4);
    check("lz_an2", 16'(an_o), 16'hF);
    check("lz_blank2", 16'(blank_o), 16'h1);
    step(4);
    check("lz_an3", 16'(an_o), 16'hF);
    check("lz_blank3", 16'(blank_o), 16'h1);
    en_i = 1'b0;
    step(1);

    // bcd_err: 00A5 sets it, A shown unblanked; 0012 clears it.
    push(16'h00A5);
    step(1);
    check("err_set", 16'(bcd_err_o), 16'h1);
    check("err_dig", 16'(digit_o), 16'h5);
    en_i = 1'b1;
    step(5);
    check("err_dig_a", 16'(digit_o), 16'hA);
    check("err_an_a", 16'(an_o), 16'hD);
    check("err_blank_a", 16'(blank_o), 16'h0);
    en_i = 1'b0;
    step(1);
    push(16'h0012);
    step(1);
    check("err_clr", 16'(bcd_err_o), 16'h0);
    check("err_clr_dig", 16'(digit_o), 16'h2);

    // Async reset mid-slot with a pending word and bcd_err set.
    push(16'h0B00);
    step(1);
    check("rs_err_pre", 16'(bcd_err_o), 16'h1);
    en_i = 1'b1;
    step(1);
    push(16'h9999);
    check("rs_pending", 16'(in_ready_o), 16'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    en_i = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    check("rs_lost_ready", 16'(in_ready_o), 16'h1);
    check("rs_lost_digit", 16'(digit_o), 16'h0);
    en_i = 1'b1;
    step(1);
    check("z_dig0", 16'(digit_o), 16'h0);
    check("z_an0", 16'(an_o), 16'hE);
    check("z_blank0", 16'(blank_o), 16'h0);
    step(4);
    check("z_an1", 16'(an_o), 16'hF);
    check("z_blank1", 16'(blank_o), 16'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
